// File: rtl/load_unit_seq_if.sv
// Request, memory and result handshake bundle for the sequential load unit.
interface load_unit_seq_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [2:0]        in_type;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              res_valid;
  logic              res_ready;
  logic [XLEN-1:0]   res_data;
  logic [1:0]        res_err;
  logic              busy;

  modport master (
    output in_valid, in_addr, in_type, mem_gnt, mem_rvalid, mem_rdata, res_ready,
    input  in_ready, mem_req, mem_addr, res_valid, res_data, res_err, busy
  );

  modport slave (
    input  in_valid, in_addr, in_type, mem_gnt, mem_rvalid, mem_rdata, res_ready,
    output in_ready, mem_req, mem_addr, res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/load_unit_seq.sv
// Sequential load unit: one request at a time, aligned memory read, lane
// select with sign/zero extension, registered result or error code.
module load_unit_seq #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset,
  load_unit_seq_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(XLEN / 8 - 1);

  localparam logic [2:0] T_LD  = 3'd1;
  localparam logic [2:0] T_LW  = 3'd2;
  localparam logic [2:0] T_LH  = 3'd3;
  localparam logic [2:0] T_LB  = 3'd4;
  localparam logic [2:0] T_LWU = 3'd5;
  localparam logic [2:0] T_LHU = 3'd6;
  localparam logic [2:0] T_LBU = 3'd7;

  localparam logic [1:0] E_OK  = 2'd0;
  localparam logic [1:0] E_MIS = 2'd1;
  localparam logic [1:0] E_ILL = 2'd2;
  localparam logic [1:0] E_TMO = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [2:0]        type_q, type_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              res_valid_q, res_valid_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;
  logic [1:0]        res_err_q, res_err_d;

  function automatic logic is_illegal(input logic [2:0] t);
    return (t == 3'd0) || ((XLEN == 32) && ((t == T_LD) || (t == T_LWU)));
  endfunction

  function automatic logic is_misaligned(input logic [2:0] t, input logic [2:0] lo);
    case (t)
      T_LD:         return lo != 3'd0;
      T_LW, T_LWU:  return lo[1:0] != 2'd0;
      T_LH, T_LHU:  return lo[0];
      default:      return 1'b0;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, extend in 64 bits, then trim to XLEN;
  // for XLEN=32 this makes LW return the full word unchanged.
  function automatic logic [XLEN-1:0] extract_lane(input logic [XLEN-1:0] word,
                                                   input logic [OFF_W-1:0] off,
                                                   input logic [2:0] t);
    logic [63:0] sh;
    logic [63:0] r;
    sh = 64'(word >> {off, 3'b000});
    case (t)
      T_LD:    r = sh;
      T_LW:    r = {{32{sh[31]}}, sh[31:0]};
      T_LH:    r = {{48{sh[15]}}, sh[15:0]};
      T_LB:    r = {{56{sh[7]}},  sh[7:0]};
      T_LWU:   r = {32'd0, sh[31:0]};
      T_LHU:   r = {48'd0, sh[15:0]};
      T_LBU:   r = {56'd0, sh[7:0]};
      default: r = 64'd0;
    endcase
    return r[XLEN-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    type_d      = type_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          off_d  = bus.in_addr[OFF_W-1:0];
          type_d = bus.in_type;
          if (is_illegal(bus.in_type)) begin
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = E_ILL;
          end else if (is_misaligned(bus.in_type, bus.in_addr[2:0])) begin
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = E_MIS;
          end else begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = bus.in_addr & ALIGN_MASK;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_data_d  = extract_lane(bus.mem_rdata, off_q, type_q);
          res_err_d   = E_OK;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_err_d   = E_TMO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          res_data_d  = '0;
          res_err_d   = E_OK;
          cnt_d       = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    off_q  <= off_d;
    type_q <= type_d;
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
endmodule

// File: doc/load_unit_seq.md
Name: load_unit_seq

Overview:
Parametrised sequential load unit for the datapath's memory stage, replacing the purely combinational load extractor.
- Accepts one load request (address plus load type) per transaction over a valid/ready handshake.
- Issues an aligned memory read and waits a variable number of cycles for the response.
- Selects the byte lane from the address offset and sign- or zero-extends it to XLEN.
- Returns a registered result, or an error code for a misaligned access, illegal type or timeout.

Parameters:
XLEN, 64, datapath and memory word width in bits; legal values 32 or 64.
ADDR_W, 64, address width in bits.
TIMEOUT, 255, maximum cycles spent in WAIT before aborting; 0 disables the timeout.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  load request valid.
in_ready  output  1  unit can accept a request; high only in IDLE.
in_addr  input  ADDR_W  byte address.
in_type  input  3  load type: 1 LD, 2 LW, 3 LH, 4 LB, 5 LWU, 6 LHU, 7 LBU; 0 illegal.
mem_req  output  1  memory read request.
mem_addr  output  ADDR_W  word-aligned address: in_addr with the low log2(XLEN/8) bits cleared.
mem_gnt  input  1  memory accepted the request.
mem_rvalid  input  1  read data valid.
mem_rdata  input  XLEN  read word.
res_valid  output  1  result or error available.
res_ready  input  1  consumer accepts the result.
res_data  output  XLEN  extended load value; 0 when res_err is nonzero.
res_err  output  2  0 ok, 1 misaligned, 2 illegal type, 3 timeout.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high) forces these values regardless of state, including mid-transaction:
  - state IDLE;
  - in_ready 1;
  - mem_req, mem_addr, res_valid, res_data, res_err, busy all 0;
  - timeout counter 0.
- All outputs are registered.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - in_ready is 1.
  - When in_valid is 1, the unit latches in_addr and in_type.
  - Illegal type → RESP with err=2 and no memory access. Illegal means type 0, or XLEN=32 with type 1 (LD) or type 5 (LWU).
  - Legal type but misaligned → RESP with err=1 and no memory access. Misaligned means:
    - LD: addr[2:0] != 0;
    - LW/LWU: addr[1:0] != 0;
    - LH/LHU: addr[0] != 0;
    - LB/LBU: never misaligned.
  - Illegal type is checked before misalignment.
  - Otherwise → REQ.
- REQ: mem_req is 1 and mem_addr is stable. On mem_gnt=1 → WAIT, and mem_req drops on the next cycle.
- WAIT:
  - mem_rvalid is sampled only in this state; an rvalid in the same cycle as gnt (in REQ) is ignored.
  - On mem_rvalid, the unit extracts the lane, registers res_data with err=0, and goes → RESP.
  - The counter increments each cycle in WAIT. If TIMEOUT > 0 and the counter reaches TIMEOUT with no rvalid → RESP with err=3.
  - A late rvalid arriving after a timeout is ignored.
- RESP: res_valid is held with res_data/res_err stable until res_ready=1; then → IDLE and res_valid drops on the next cycle.
- Throughput: no overlap between transactions; a new request is accepted only in IDLE. Best-case latency from accept to res_valid is 3 cycles: gnt in the first REQ cycle and rvalid in the first WAIT cycle.
- Lane select: off = latched addr[log2(XLEN/8)-1:0]. The field is mem_rdata[8*off +: size], with size = 8/16/32/64 bits.
- Extension rules:
  - LD: the full word, unchanged.
  - LW/LH/LB: sign-extended from the field's MSB to XLEN.
  - LWU/LHU/LBU: zero-extended to XLEN.
  - LW with XLEN=32: the full word, unchanged.
- in_valid while busy is ignored; in_ready=0 tells the requester to hold.

Test Plan:
1. XLEN=64; mem_rdata=0x8899AABBCCDDEEFF. LH @0x1006 → res_data=0xFFFFFFFFFFFF8899, err=0. LHU @0x1006 → 0x0000000000008899. mem_addr=0x1000 in both cases.
2. Same data. LB @0x1005 → 0xFFFFFFFFFFFFFFAA. LBU @0x1001 → 0xEE. LW @0x1004 → 0xFFFFFFFF8899AABB. LWU @0x1000 → 0x00000000CCDDEEFF. LD @0x1000 → 0x8899AABBCCDDEEFF.
3. Error paths:
   - LW @0x1002 → err=1, res_data=0, and mem_req is never asserted.
   - in_type=0 → err=2.
   - XLEN=32 with LD → err=2.
4. Handshake timing: gnt delayed 3 cycles, rvalid 5 cycles after gnt, res_ready held low 4 cycles → res_valid and res_data stay stable throughout; in_ready=0 until the cycle after res_ready.
5. TIMEOUT=4 with rvalid never asserted → err=3 after 4 WAIT cycles. A later rvalid is ignored, and the next request completes normally.
6. reset=1 asserted in WAIT → the next cycle shows IDLE, in_ready=1 and all other outputs 0. A stale rvalid arriving after reset produces no res_valid.
